// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, the instruction memory and the core.
// master = prefetch queue side, slave = memory/core side.
interface instr_prefetch_queue_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [CNT_W-1:0]  count;

  // Handshake: a word transfers on any rising clock edge where instr_valid and
  // instr_ready are both 1; instr/instr_pc are stable while valid waits for ready.
  // mem_rd is a one-cycle request; mem_rdata answers in the following cycle.
  modport master (
    output mem_rd, mem_addr,
    input  mem_rdata,
    input  flush, flush_pc,
    output instr_valid,
    input  instr_ready,
    output instr, instr_pc, count
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_rdata,
    output flush, flush_pc,
    input  instr_valid,
    output instr_ready,
    input  instr, instr_pc, count
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with a small FIFO and flush/redirect.
// Optional PREFETCH_HALT_STOP_EN: stop fetching once a HALT word is enqueued.
module instr_prefetch_queue #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 4064
) (
  input  logic                   clock,
  input  logic                   reset_n,
  instr_prefetch_queue_if.master bus,
  output logic [1:0]             dbg_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_V = RESET_PC[ADDR_W-1:0];

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FULL = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] ret_pc_q;
  logic              inflight_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  occupancy, occ_d;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic issue, push, pop, kill, halt_hit;

  // In-flight requests reserve a slot, so a returning word always fits.
  assign occupancy = count_q + {{(CNT_W-1){1'b0}}, inflight_q};
  assign issue     = reset_n && (state_q == ST_RUN) && !bus.flush
                     && (occupancy < CNT_W'(DEPTH));

  // Returning data is dropped when it belongs to a stream being redirected or
  // arrives after the HALT word stopped fetching.
  assign kill = bus.flush || (state_q == ST_HALT);
  assign push = inflight_q && !kill;
  assign pop  = (count_q != '0) && bus.instr_ready && !bus.flush;

`ifdef PREFETCH_HALT_STOP_EN
  assign halt_hit = push && (bus.mem_rdata[DATA_W-1 -: 4] == 4'b1000);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    if (bus.flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!push && pop)
      count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    occ_d   = count_d + {{(CNT_W-1){1'b0}}, issue};
    if (bus.flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_hit)
            state_d = ST_HALT;
          else if (occ_d == CNT_W'(DEPTH))
            state_d = ST_FULL;
        end
        ST_FULL: begin
          if (halt_hit)
            state_d = ST_HALT;
          else if (occ_d < CNT_W'(DEPTH))
            state_d = ST_RUN;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC_V;
      ret_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue)
        ret_pc_q <= fetch_pc_q;
      if (bus.flush) begin
        fetch_pc_q <= bus.flush_pc;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (issue)
          fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
        if (push) begin
          data_mem[wr_ptr_q] <= bus.mem_rdata;
          pc_mem[wr_ptr_q]   <= ret_pc_q;
          wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign bus.mem_rd      = issue;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = data_mem[rd_ptr_q];
  assign bus.instr_pc    = pc_mem[rd_ptr_q];
  assign bus.count       = count_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed testbench for instr_prefetch_queue: memory model holds addr=data.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_instr_prefetch_queue;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_fail = 0;

  logic [DATA_W-1:0] mem [4096];
  logic [ADDR_W-1:0] exp_q [$];

  instr_prefetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  instr_prefetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(4064)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / memory model
  always #5 clock = ~clock;

  always @(posedge clock)
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  // drain: pop words while ready=1 and compare against exp_q in order
  task automatic drain(input string name, input int budget);
    logic [ADDR_W-1:0] e;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      if (bus.instr_valid === 1'b1) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.instr_pc !== e) begin
          n_fail++;
          $display("FAIL %s_pc: got %0d want %0d", name, bus.instr_pc, e);
        end
        n_cmp++;
        if (bus.instr !== mem[e]) begin
          n_fail++;
          $display("FAIL %s_instr: got %h want %h", name, bus.instr, mem[e]);
        end
      end
      @(negedge clock); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words missing, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    bus.instr_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
    n_cmp++; if (bus.mem_addr !== 12'd4064) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 4064", bus.mem_addr); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
    n_cmp++; if (bus.instr_pc !== 12'd0) begin n_fail++; $display("FAIL reset_instr_pc: got %0d want 0", bus.instr_pc); end
    n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_stream;
    logic [ADDR_W-1:0] a, p;
    @(negedge clock);
    reset_n = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      a = ADDR_W'(4064 + k);
      p = ADDR_W'(4064 + k - 2);
      n_cmp++; if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL stream_mem_rd[%0d]: got %b want 1", k, bus.mem_rd); end
      n_cmp++; if (bus.mem_addr !== a) begin n_fail++; $display("FAIL stream_mem_addr[%0d]: got %0d want %0d", k, bus.mem_addr, a); end
      if (k < 2) begin
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 0", k, bus.instr_valid); end
      end else begin
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.instr_valid); end
        n_cmp++; if (bus.instr_pc !== p) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0d want %0d", k, bus.instr_pc, p); end
        n_cmp++; if (bus.instr !== DATA_W'(p)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", k, bus.instr, DATA_W'(p)); end
        n_cmp++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 1", k, bus.count); end
      end
      @(negedge clock); #1;
    end
  endtask

  task automatic test_backpressure;
    logic want_rd;
    @(negedge clock);
    reset_n = 1'b0;
    bus.instr_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      want_rd = (k < 4);
      n_cmp++; if (bus.mem_rd !== want_rd) begin n_fail++; $display("FAIL bp_mem_rd[%0d]: got %b want %b", k, bus.mem_rd, want_rd); end
      if (k < 4) begin
        n_cmp++; if (bus.mem_addr !== ADDR_W'(4064 + k)) begin n_fail++; $display("FAIL bp_mem_addr[%0d]: got %0d want %0d", k, bus.mem_addr, 4064 + k); end
      end
      @(negedge clock); #1;
    end
    n_cmp++; if (bus.count !== CNT_W'(4)) begin n_fail++; $display("FAIL bp_count_full: got %0d want 4", bus.count); end
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL bp_state_full: got %0d want 1", dbg_state); end
    n_cmp++; if (bus.instr_pc !== 12'd4064) begin n_fail++; $display("FAIL bp_head_pc: got %0d want 4064", bus.instr_pc); end
    bus.instr_ready = 1'b1;
    #1;
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_rd_during_pop: got %b want 0", bus.mem_rd); end
    @(negedge clock);
    bus.instr_ready = 1'b0;
    #1;
    n_cmp++; if (bus.count !== CNT_W'(3)) begin n_fail++; $display("FAIL bp_count_after_pop: got %0d want 3", bus.count); end
    n_cmp++; if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL bp_refill_rd: got %b want 1", bus.mem_rd); end
    n_cmp++; if (bus.mem_addr !== 12'd4068) begin n_fail++; $display("FAIL bp_refill_addr: got %0d want 4068", bus.mem_addr); end
    n_cmp++; if (bus.instr_pc !== 12'd4065) begin n_fail++; $display("FAIL bp_head_after_pop: got %0d want 4065", bus.instr_pc); end
    @(negedge clock); #1;
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_refull_rd: got %b want 0", bus.mem_rd); end
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL bp_refull_state: got %0d want 1", dbg_state); end
  endtask

  task automatic test_wrap;
    @(negedge clock);
    bus.flush = 1'b1;
    bus.flush_pc = 12'd4094;
    bus.instr_ready = 1'b1;
    #1;
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL wrap_flush_rd: got %b want 0", bus.mem_rd); end
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    n_cmp++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL wrap_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.mem_addr !== 12'd4094) begin n_fail++; $display("FAIL wrap_first_addr: got %0d want 4094", bus.mem_addr); end
    exp_q = '{12'd4094, 12'd4095, 12'd0, 12'd1};
    drain("wrap", 20);
  endtask

  task automatic test_flush_mid;
    @(negedge clock);
    bus.flush = 1'b1;
    bus.flush_pc = 12'd200;
    bus.instr_ready = 1'b0;
    @(negedge clock);
    bus.flush = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    n_cmp++; if (bus.count !== CNT_W'(3)) begin n_fail++; $display("FAIL mid_setup_count: got %0d want 3", bus.count); end
    n_cmp++; if (bus.instr_pc !== 12'd200) begin n_fail++; $display("FAIL mid_setup_head: got %0d want 200", bus.instr_pc); end
    bus.flush = 1'b1;
    bus.flush_pc = 12'd100;
    #1;
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL mid_flush_rd: got %b want 0", bus.mem_rd); end
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    n_cmp++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL mid_count_after: got %0d want 0", bus.count); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_after: got %b want 0", bus.instr_valid); end
    bus.instr_ready = 1'b1;
    exp_q = '{12'd100, 12'd101, 12'd102};
    drain("mid", 20);
  endtask

  task automatic test_flush_pop;
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL fp_setup_valid: got %b want 1", bus.instr_valid); end
    bus.flush = 1'b1;
    bus.flush_pc = 12'd300;
    #1;
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL fp_flush_rd: got %b want 0", bus.mem_rd); end
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    n_cmp++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL fp_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL fp_refetch_rd: got %b want 1", bus.mem_rd); end
    n_cmp++; if (bus.mem_addr !== 12'd300) begin n_fail++; $display("FAIL fp_refetch_addr: got %0d want 300", bus.mem_addr); end
    exp_q = '{12'd300, 12'd301};
    drain("fp", 20);
  endtask

  task automatic test_halt;
    logic want_rd;
    mem[4066] = 32'h8000_0000;
    @(negedge clock);
    bus.flush = 1'b1;
    bus.flush_pc = 12'd4064;
    bus.instr_ready = 1'b0;
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    for (int k = 0; k < 7; k++) begin
      want_rd = (k < 4);
      n_cmp++; if (bus.mem_rd !== want_rd) begin n_fail++; $display("FAIL halt_mem_rd[%0d]: got %b want %b", k, bus.mem_rd, want_rd); end
      @(negedge clock); #1;
    end
`ifdef PREFETCH_HALT_STOP_EN
    n_cmp++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL halt_state: got %0d want 2", dbg_state); end
    n_cmp++; if (bus.count !== CNT_W'(3)) begin n_fail++; $display("FAIL halt_count: got %0d want 3", bus.count); end
    bus.instr_ready = 1'b1;
    exp_q = '{12'd4064, 12'd4065, 12'd4066};
    drain("halt", 20);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_idle_rd[%0d]: got %b want 0", k, bus.mem_rd); end
      @(negedge clock); #1;
    end
    n_cmp++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL halt_drained: got %0d want 0", bus.count); end
    bus.flush = 1'b1;
    bus.flush_pc = 12'd10;
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL halt_exit_state: got %0d want 0", dbg_state); end
    n_cmp++; if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL halt_exit_rd: got %b want 1", bus.mem_rd); end
    n_cmp++; if (bus.mem_addr !== 12'd10) begin n_fail++; $display("FAIL halt_exit_addr: got %0d want 10", bus.mem_addr); end
`else
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL nohalt_state: got %0d want 1", dbg_state); end
    n_cmp++; if (bus.count !== CNT_W'(4)) begin n_fail++; $display("FAIL nohalt_count: got %0d want 4", bus.count); end
    bus.instr_ready = 1'b1;
    exp_q = '{12'd4064, 12'd4065, 12'd4066, 12'd4067, 12'd4068};
    drain("nohalt", 20);
`endif
    mem[4066] = 32'd4066;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DATA_W'(i);
    bus.mem_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_flush_mid();
    test_flush_pop();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Instruction fetch stage sitting between the 4K x 32 instruction/data memory and the processor core.
- Issues sequential read requests starting from the reset PC.
- Buffers returned 32-bit instruction words with their addresses in a small FIFO.
- Presents words to the core over a valid/ready handshake.
- Core branches are applied through a flush/redirect input that discards queued and in-flight words.

Parameters:
ADDR_W, 12, instruction address width (4096-word space)
DATA_W, 32, instruction word width
DEPTH, 4, FIFO entries (power of 2, >= 2)
RESET_PC, 4064, first fetch address after reset (4095 - 31)

Ports:
clock  input  1  single clock, all state on posedge
reset_n  input  1  asynchronous active-low reset
mem_rd  output  1  read request to memory, one word per cycle
mem_addr  output  ADDR_W  read address, valid while mem_rd=1
mem_rdata  input  DATA_W  read data, valid the cycle after a request is sampled
flush  input  1  redirect strobe from core (branch taken)
flush_pc  input  ADDR_W  redirect target, sampled when flush=1
instr_valid  output  1  head entry valid
instr_ready  input  1  core accepts head entry
instr  output  DATA_W  head instruction word
instr_pc  output  ADDR_W  address of head word
count  output  clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (async assert, sync-safe deassert): fetch_pc=RESET_PC, count=0, in-flight flag=0, state=RUN; mem_rd=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Memory timing: a request with mem_rd=1 in cycle N is sampled at the end of N. mem_rdata is valid in N+1 and written into the FIFO at the end of N+1. instr_valid is first seen in N+2, giving 2-cycle issue-to-valid latency.
- Issue rule: mem_rd=1 iff state=RUN, flush=0 and (count + inflight) < DEPTH. On issue, fetch_pc increments by 1 modulo 2^ADDR_W (4095 wraps to 0). Sustained throughput is 1 word/cycle when the core accepts every cycle.
- Slot reservation: in-flight requests count against capacity, so returning data always has a free entry. Overflow is impossible by construction.
- Pop: instr_valid && instr_ready removes the head at the clock edge. Push and pop in the same cycle leaves count unchanged. Empty: instr_valid=0; instr/instr_pc hold their last values and are don't-care.
- instr_valid = (count != 0). instr/instr_pc come from the head registers, with no combinational path from mem_rdata.
- Flush (highest priority):
  - At the edge: count->0, head/tail pointers->0, fetch_pc<=flush_pc, state->RUN.
  - mem_rd=0 during the flush cycle.
  - Data returning in the flush cycle or the following cycle for a pre-flush request is discarded via a kill bit.
  - A pop in the flush cycle is ignored (the core must treat a flushed word as not consumed).
  - First fetch of flush_pc is issued the cycle after flush.
- Back-to-back flushes: the last one wins; no stale word is ever enqueued.
- State machine:
  - RUN: issuing as allowed.
  - FULL: count + inflight == DEPTH; return to RUN when a pop frees a slot.
  - HALT: only with the optional feature. Exit only via flush or reset.
- Reset mid-operation: everything returns to reset values immediately. Any memory data returning after reset is ignored because the in-flight flag is 0.

Optional Feature:
PREFETCH_HALT_STOP_EN
- Defined: when a word whose bits [31:28]=4'b1000 (HALT) is enqueued, state->HALT and no further requests are issued. Queued words, including the HALT, still drain normally. flush returns the block to RUN.
- Undefined: opcodes are not inspected; the block fetches sequentially forever (the core simply stops popping after HALT). HALT state is unreachable.

Test Plan:
- Reset release, instr_ready=1, memory loaded addr=data -> mem_addr 4064,4065,... one per cycle; first instr_valid 2 cycles after first mem_rd with instr=mem[4064], instr_pc=4064; consecutive words thereafter.
- instr_ready=0 held -> exactly DEPTH=4 requests issued (4064..4067), count=4, mem_rd=0 afterwards; raise ready one cycle -> one pop, one new request for 4068.
- Fetch across wrap: flush_pc=4094 -> instr_pc sequence 4094,4095,0,1.
- flush with flush_pc=100 while count=3 and one request in flight -> next instr_valid shows instr_pc=100; no word from old stream ever appears; count=0 the cycle after flush.
- Simultaneous flush and pop (valid=1, ready=1) -> flush wins; head not delivered; refetch starts at flush_pc.
- With PREFETCH_HALT_STOP_EN, memory word at 4066 = 32'h8000_0000 -> requests stop after 4066 enters the queue; words 4064–4066 drain; mem_rd stays 0 until flush. Without the macro, fetch continues to 4067+.
